// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating direction counters, EX-stage
// resolution, registered redirect on mispredict, and branch/mispredict stats.
module branch_predict_unit #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_if,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned TAG_W = 30 - IDX;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

    // Table storage
    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    // EX-side lookup and entry update
    logic [IDX-1:0]      ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    logic                ex_hit;
    logic                mispredict;
    logic                ent_we;
    logic                ent_valid_d;
    logic [TAG_W-1:0]    ent_tag_d;
    logic [31:0]         ent_target_d;
    logic [CTR_BITS-1:0] ent_ctr_d;

    // Redirect and statistics
    logic             redirect_d,    redirect_q;
    logic [31:0]      redirect_pc_d, redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_d,  branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

    // Word-alignment bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], ex_pc[1:0]};

    always_comb begin
        f_idx       = pc_if[IDX+1:2];
        f_tag       = pc_if[31:IDX+2];
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][CTR_BITS-1];
        pred_target = pred_taken ? target_q[f_idx] : pc_if + 32'd4;
    end

    always_comb begin
        ex_idx = ex_pc[IDX+1:2];
        ex_tag = ex_pc[31:IDX+2];
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    end

    always_comb begin
        mispredict = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch) begin
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            end else begin
                mispredict = ex_pred_taken;
            end
        end
    end

    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[ex_idx];
        ent_tag_d    = tag_q[ex_idx];
        ent_target_d = target_q[ex_idx];
        ent_ctr_d    = ctr_q[ex_idx];
        if (ex_valid && ex_is_branch) begin
            if (ex_hit) begin
                ent_we = 1'b1;
                if (ex_taken) begin
                    ent_target_d = ex_target;
                    if (ctr_q[ex_idx] != CTR_MAX) begin
                        ent_ctr_d = ctr_q[ex_idx] + 1'b1;
                    end
                end else if (ctr_q[ex_idx] != '0) begin
                    ent_ctr_d = ctr_q[ex_idx] - 1'b1;
                end
            end else if (ex_taken) begin
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = ex_tag;
                ent_target_d = ex_target;
                ent_ctr_d    = CTR_WEAK;
            end
        end else if (ex_valid && ex_pred_taken && ex_hit) begin
            // A non-branch predicted taken means the entry aliases; drop it.
            ent_we      = 1'b1;
            ent_valid_d = 1'b0;
        end
    end

    // Writes land on the clock edge, so same-cycle fetch sees old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (ent_we) begin
            valid_q[ex_idx]  <= ent_valid_d;
            tag_q[ex_idx]    <= ent_tag_d;
            target_q[ex_idx] <= ent_target_d;
            ctr_q[ex_idx]    <= ent_ctr_d;
        end
    end

    always_comb begin
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        if (mispredict) begin
            redirect_pc_d = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
        end

        branch_cnt_d = branch_cnt_q;
        if (ex_valid && ex_is_branch && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end

        mispred_cnt_d = mispred_cnt_q;
        if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: stimulus pushes expected redirects, predictions and stats;
// a negedge monitor pops and compares them against the DUT.
module tb_branch_predict_unit;

    localparam int unsigned ENTRIES  = 16;
    localparam int unsigned CTR_BITS = 2;
    localparam int unsigned CNT_W    = 4;

    logic             clk;
    logic             reset;
    logic [31:0]      pc_if;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_is_branch;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_predict_unit #(
        .ENTRIES (ENTRIES),
        .CTR_BITS(CTR_BITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_if         (pc_if),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    typedef struct {
        int          due;
        logic [31:0] pc;
    } redir_t;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
    } pred_t;

    typedef struct {
        logic [CNT_W-1:0] b;
        logic [CNT_W-1:0] m;
        logic             chk_rd;
        logic             rd;
        logic [31:0]      rdpc;
    } stat_t;

    redir_t redir_q[$];
    pred_t  pred_q[$];
    stat_t  stat_q[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic done  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        redir_t r;
        pred_t  p;
        stat_t  s;
        if (redirect) begin
            total++;
            if (redir_q.size() > 0 && redir_q[0].due == cyc) begin
                r = redir_q.pop_front();
                if (redirect_pc !== r.pc) begin
                    bad++;
                    $display("FAIL redirect_pc cyc=%0d: got %h want %h", cyc, redirect_pc, r.pc);
                end
            end else begin
                bad++;
                $display("FAIL unexpected_redirect cyc=%0d: got redirect=1 pc=%h want 0",
                         cyc, redirect_pc);
            end
        end else if (redir_q.size() > 0 && redir_q[0].due <= cyc) begin
            r = redir_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_redirect cyc=%0d: got 0 want redirect to %h", cyc, r.pc);
        end
        if (pred_q.size() > 0) begin
            p = pred_q.pop_front();
            total++;
            if (pred_taken !== p.tk || pred_target !== p.tgt) begin
                bad++;
                $display("FAIL pred pc=%h: got taken=%b target=%h want taken=%b target=%h",
                         p.pc, pred_taken, pred_target, p.tk, p.tgt);
            end
        end
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            total++;
            if (branch_cnt !== s.b || mispred_cnt !== s.m ||
                (s.chk_rd && (redirect !== s.rd || redirect_pc !== s.rdpc))) begin
                bad++;
                $display("FAIL stats: got b=%0d m=%0d rd=%b rdpc=%h want b=%0d m=%0d rd=%b rdpc=%h",
                         branch_cnt, mispred_cnt, redirect, redirect_pc,
                         s.b, s.m, s.rd, s.rdpc);
            end
        end
        if (done) begin
            total++;
            if (redir_q.size() != 0 || pred_q.size() != 0 || stat_q.size() != 0) begin
                bad++;
                $display("FAIL sb_drain: got %0d/%0d/%0d pending want 0/0/0",
                         redir_q.size(), pred_q.size(), stat_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic ex_op(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic ppt, input logic [31:0] pptgt,
                         input logic exp_rd, input logic [31:0] exp_pc);
        redir_t r;
        @(posedge clk);
        #1;
        ex_valid       = v;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ppt;
        ex_pred_target = pptgt;
        if (exp_rd) begin
            r.due = cyc + 1;
            r.pc  = exp_pc;
            redir_q.push_back(r);
        end
    endtask

    task automatic pred_chk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        pred_t p;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        pc_if    = pc;
        p.pc = pc; p.tk = tk; p.tgt = tgt;
        pred_q.push_back(p);
    endtask

    task automatic stat_chk(input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] m,
                            input logic chk_rd, input logic rd, input logic [31:0] rdpc);
        stat_t s;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        s.b = b; s.m = m; s.chk_rd = chk_rd; s.rd = rd; s.rdpc = rdpc;
        stat_q.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stat_t s;
        pred_t p;
        reset = 1'b1;
        pc_if = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0;
        ex_taken = 1'b0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        stat_chk(4'd0, 4'd0, 1'b1, 1'b0, 32'h0);
        pred_chk(32'h100, 1'b0, 32'h104);

        // Cold miss allocation
        ex_op(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
        stat_chk(4'd1, 4'd1, 1'b0, 1'b0, 32'h0);
        pred_chk(32'h100, 1'b1, 32'h200);

        // Hysteresis: 2 -> 1 -> 2 -> 3 -> 2
        ex_op(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        pred_chk(32'h100, 1'b0, 32'h104);
        ex_op(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
        ex_op(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        ex_op(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        pred_chk(32'h100, 1'b1, 32'h200);
        stat_chk(4'd5, 4'd4, 1'b0, 1'b0, 32'h0);

        // Aliasing: tag mismatch, then non-branch cleanup
        pred_chk(32'h140, 1'b0, 32'h144);
        ex_op(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        pred_chk(32'h100, 1'b0, 32'h104);

        // Not-taken miss must not allocate
        ex_op(1'b1, 32'h180, 1'b1, 1'b0, 32'h0, 1'b0, 32'h184, 1'b0, 32'h0);
        pred_chk(32'h180, 1'b0, 32'h184);

        // Wrong target
        ex_op(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
        pred_chk(32'h100, 1'b1, 32'h200);
        ex_op(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
        pred_chk(32'h100, 1'b1, 32'h300);
        stat_chk(4'd8, 4'd7, 1'b0, 1'b0, 32'h0);

        // ex_valid=0 is ignored
        ex_op(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        pred_chk(32'h100, 1'b1, 32'h300);
        stat_chk(4'd8, 4'd7, 1'b1, 1'b0, 32'h300);

        // pc_if+4 wraps
        pred_chk(32'hFFFF_FFFC, 1'b0, 32'h0);

        // 20 back-to-back mispredicts saturate a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            ex_op(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h44);
        end
        stat_chk(4'd8, 4'd15, 1'b0, 1'b0, 32'h0);
        pred_chk(32'h100, 1'b1, 32'h300);

        // Reset while a redirect pulse is live
        ex_op(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        #1 reset = 1'b1;
        pc_if = 32'h100;
        s.b = '0; s.m = '0; s.chk_rd = 1'b1; s.rd = 1'b0; s.rdpc = 32'h0;
        stat_q.push_back(s);
        p.pc = 32'h100; p.tk = 1'b0; p.tgt = 32'h104;
        pred_q.push_back(p);
        @(posedge clk);
        #1 reset = 1'b0;
        stat_chk(4'd0, 4'd0, 1'b1, 1'b0, 32'h0);
        pred_chk(32'h100, 1'b0, 32'h104);

        // Table works again after reset
        ex_op(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
        pred_chk(32'h100, 1'b1, 32'h200);
        stat_chk(4'd1, 4'd1, 1'b0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped BTB entries (power of 2, 2..256).
REQ-002 SHALL have parameter CTR_BITS, default 2, width of per-entry saturating direction counter (1..4).
REQ-003 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc_if  input  32  fetch-stage PC to predict.
REQ-007 SHALL have port pred_taken  output  1  prediction for pc_if (combinational).
REQ-008 SHALL have port pred_target  output  32  predicted next PC for pc_if (combinational).
REQ-009 SHALL have port ex_valid  input  1  EX-stage instruction valid this cycle.
REQ-010 SHALL have port ex_pc  input  32  PC of EX-stage instruction.
REQ-011 SHALL have port ex_is_branch  input  1  EX instruction is a conditional branch or J/JAL.
REQ-012 SHALL have port ex_taken  input  1  resolved branch outcome.
REQ-013 SHALL have port ex_target  input  32  resolved taken target.
REQ-014 SHALL have port ex_pred_taken  input  1  pred_taken carried down the pipe with this instruction.
REQ-015 SHALL have port ex_pred_target  input  32  pred_target carried down the pipe with this instruction.
REQ-016 SHALL have port redirect  output  1  registered one-cycle pulse: flush younger instructions and refetch.
REQ-017 SHALL have port redirect_pc  output  32  registered corrected fetch PC, valid when redirect=1.
REQ-018 SHALL have ports branch_cnt, mispred_cnt  output  CNT_W  registered statistics.

Function
REQ-019 SHALL index the table with pc[IDX+1:2], IDX=log2(ENTRIES); tag = pc[31:IDX+2]; each entry holds valid, tag, 32-bit target, CTR_BITS counter.
REQ-020 SHALL define fetch hit = entry valid AND tag equals pc_if tag.
REQ-021 SHALL drive pred_taken = hit AND counter MSB; pred_target = stored target when pred_taken, else pc_if+4 (32-bit wrap).
REQ-022 SHALL define mispredict (when ex_valid) as: branch with ex_taken != ex_pred_taken; OR branch with ex_taken=1 and ex_target != ex_pred_target; OR non-branch with ex_pred_taken=1.
REQ-023 SHALL, on the edge after a mispredict, assert redirect for exactly one cycle, with redirect_pc = ex_target if ex_is_branch AND ex_taken, else ex_pc+4.
REQ-024 SHALL hold redirect=0 in every cycle not immediately following a mispredict; back-to-back mispredicts give back-to-back pulses.
REQ-025 SHALL, for ex_valid AND ex_is_branch on EX hit: increment counter (saturating at all-ones) if taken, decrement (saturating at 0) if not; overwrite target with ex_target if taken.
REQ-026 SHALL, for ex_valid AND ex_is_branch on EX miss with ex_taken=1, allocate: valid=1, tag, target=ex_target, counter=2^(CTR_BITS-1) (weakly taken), replacing any occupant.
REQ-027 SHALL NOT allocate on a not-taken miss.
REQ-028 SHALL clear valid for the EX-hit entry when ex_valid AND NOT ex_is_branch AND ex_pred_taken (alias cleanup).
REQ-029 SHALL give a same-cycle fetch lookup of an entry being updated the pre-update contents; the update is visible from the next cycle.
REQ-030 SHALL increment branch_cnt per ex_valid AND ex_is_branch, and mispred_cnt per mispredict, both saturating at all-ones.
REQ-031 SHALL ignore all EX inputs when ex_valid=0 (no table, counter or redirect change).

Reset
REQ-032 SHALL, while reset=1 (asynchronously, including mid-operation), clear all valid bits and counters, redirect=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0.
REQ-033 SHALL produce pred_taken=0, pred_target=pc_if+4 in the first cycle after reset.

Verification
REQ-034 SHALL cover cold miss: after reset, EX branch ex_pc=0x100, taken, target 0x200, ex_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x200; then pc_if=0x100 -> pred_taken=1, pred_target=0x200.
REQ-035 SHALL cover hysteresis (CTR_BITS=2): after allocation (counter 2), one not-taken at 0x100 -> redirect_pc=0x104, counter 1, pred_taken=0; two takens -> counter 3; one not-taken -> still pred_taken=1.
REQ-036 SHALL cover aliasing: ENTRIES=16, entry allocated at 0x100; pc_if=0x140 -> pred_taken=0 (tag mismatch); non-branch at 0x100 with ex_pred_taken=1 -> redirect_pc=0x104, entry invalidated.
REQ-037 SHALL cover wrong target: hit at 0x100 predicted 0x200, resolves taken to 0x300 -> redirect_pc=0x300, stored target becomes 0x300.
REQ-038 SHALL cover saturation and reset: CNT_W=4, 20 mispredicts -> mispred_cnt=0xF; assert reset mid-stream -> counters 0, redirect 0, pred_taken 0 immediately.
